// File: rtl/curl_avalon_ctrl.sv
// rtl/curl_avalon_ctrl.sv - Avalon-MM slave that loads, launches and collects one curl core transform
// Host fills a 32-word input buffer, pulses START, and reads back the captured 1024-bit result.
module curl_avalon_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic [3:0]    avs_byteenable,
  output logic [31:0]   avs_readdata,
  output logic          avs_readdatavalid,
  output logic          avs_waitrequest,
  output logic          irq,
  output logic          core_start,
  output logic [1023:0] core_data_in,
  input  logic          core_done,
  input  logic [1023:0] core_data_out
);

  // Only a read latency of 1 is implemented; any other value never returns read data.
  localparam logic        LAT_OK  = (READ_LATENCY == 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t        r_state;
  logic          r_core_start;
  logic [1023:0] r_core_data_in;
  logic [31:0]   r_cnt;
  logic [31:0]   r_cycles;
  logic [31:0]   r_in_buf  [32];
  logic [31:0]   r_res_buf [32];
  logic          r_done;
  logic          r_timeout;
  logic          r_wr_err;
  logic          r_irq_en;
  logic          r_irq;
  logic          r_rvalid;
  logic [31:0]   r_rdata;

  logic          w_busy;
  logic          w_ctrl_wr;
  logic          w_buf_wr;
  logic          w_clear;
  logic          w_start;
  logic          w_done_ev;
  logic          w_to_ev;
  logic          w_done_nxt;
  logic          w_timeout_nxt;
  logic          w_wr_err_nxt;
  logic          w_irq_en_nxt;
  logic [31:0]   w_rmux;

  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_ctrl_wr = avs_write && (avs_address == 6'h00);
    w_buf_wr  = avs_write && avs_address[5];
    w_clear   = w_ctrl_wr && avs_writedata[1];
    w_start   = w_ctrl_wr && avs_writedata[0] && !avs_writedata[1] && !w_busy;
    w_done_ev = (r_state == S_WAIT) && core_done && !w_clear;
    w_to_ev   = (r_state == S_WAIT) && !core_done && !w_clear &&
                (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    w_done_nxt    = r_done;
    w_timeout_nxt = r_timeout;
    w_wr_err_nxt  = r_wr_err;
    if (w_clear) begin
      w_done_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;
      w_wr_err_nxt  = 1'b0;
    end else begin
      if (w_start) begin
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
      end
      if (w_done_ev) w_done_nxt = 1'b1;
      if (w_to_ev) w_timeout_nxt = 1'b1;
      if (w_buf_wr && w_busy) w_wr_err_nxt = 1'b1;
    end
    w_irq_en_nxt = w_ctrl_wr ? avs_writedata[2] : r_irq_en;

    w_rmux = '0;
    if (avs_address[5]) begin
      w_rmux = r_res_buf[avs_address[4:0]];
    end else begin
      case (avs_address[4:0])
        5'h01:   w_rmux = {28'd0, r_wr_err, r_timeout, r_done, w_busy};
        5'h02:   w_rmux = r_cycles;
        default: w_rmux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_core_start   <= 1'b0;
      r_core_data_in <= '0;
      r_cnt          <= '0;
      r_cycles       <= '0;
      for (int i = 0; i < 32; i++) r_res_buf[i] <= '0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state      <= S_LAUNCH;
            r_core_start <= 1'b1;
            r_cnt        <= '0;
            for (int i = 0; i < 32; i++) r_core_data_in[i*32 +: 32] <= r_in_buf[i];
          end
        end
        S_LAUNCH: r_state <= w_clear ? S_IDLE : S_WAIT;
        S_WAIT: begin
          if (w_clear) begin
            r_state <= S_IDLE;
          end else if (core_done) begin
            for (int i = 0; i < 32; i++) r_res_buf[i] <= core_data_out[i*32 +: 32];
            r_cycles <= r_cnt + 32'd1;
            r_state  <= S_IDLE;
          end else if (w_to_ev) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_wr_err  <= 1'b0;
      r_irq_en  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
      r_wr_err  <= w_wr_err_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_irq     <= w_irq_en_nxt && (w_done_nxt || w_timeout_nxt);
    end
  end

  // The snapshot into core_data_in keeps the core input stable, so writes while busy are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_in_buf[i] <= '0;
    end else if (w_buf_wr && !w_busy) begin
      for (int b = 0; b < 4; b++) begin
        if (avs_byteenable[b]) r_in_buf[avs_address[4:0]][b*8 +: 8] <= avs_writedata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= avs_read && LAT_OK;
      r_rdata  <= (avs_read && LAT_OK) ? w_rmux : 32'd0;
    end
  end

  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign avs_waitrequest   = 1'b0;
  assign irq               = r_irq;
  assign core_start        = r_core_start;
  assign core_data_in      = r_core_data_in;

endmodule

// File: tb/tb_curl_avalon_ctrl.sv
// tb/tb_curl_avalon_ctrl.sv - randomized self-checking bench for curl_avalon_ctrl
`timescale 1ns/1ps
module tb_curl_avalon_ctrl;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [3:0]    avs_byteenable = '0;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic          avs_waitrequest;
  logic          irq;
  logic          core_start;
  logic [1023:0] core_data_in;
  logic          core_done = 1'b0;
  logic [1023:0] core_data_out = '0;

  int total = 0;
  int bad = 0;

  bit            core_en = 1'b1;
  int            core_lat = 10;
  int            cd = 0;
  bit            late_req = 1'b0;
  int            n_starts = 0;
  logic [1023:0] seen_in = '0;

  logic [31:0] exp_in  [32];
  logic [31:0] exp_res [32];
  logic [31:0] exp_cycles = '0;

  always #5 clk = ~clk;

  curl_avalon_ctrl #(.TIMEOUT_CYCLES(TO), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest), .irq(irq),
    .core_start(core_start), .core_data_in(core_data_in),
    .core_done(core_done), .core_data_out(core_data_out)
  );

  // Core model: answers ~input core_lat cycles after the launch pulse.
  always @(negedge clk) begin
    core_done <= 1'b0;
    if (core_start) begin
      n_starts <= n_starts + 1;
      seen_in  <= core_data_in;
      cd       <= core_en ? core_lat : 0;
    end else if (cd == 1) begin
      cd            <= 0;
      core_done     <= 1'b1;
      core_data_out <= ~seen_in;
    end else if (cd > 1) begin
      cd <= cd - 1;
    end else if (late_req) begin
      core_done     <= 1'b1;
      core_data_out <= {32{$urandom}};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [1023:0] pack_in();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = exp_in[i];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; avs_byteenable = '0;
  endtask

  task automatic buf_wr(input int n, input logic [31:0] d, input logic [3:0] be);
    bus_wr(6'(32 + n), d, be);
    for (int b = 0; b < 4; b++) if (be[b]) exp_in[n][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d, output logic v);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata; v = avs_readdatavalid;
  endtask

  task automatic wait_done(output int ok);
    logic [31:0] d; logic v;
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      bus_rd(6'h01, d, v);
      if (d[1]) ok = 1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    reset = 1'b1;
    tick(2);
    total++; if ({irq, core_start, avs_readdatavalid, avs_waitrequest} !== 4'b0) begin bad++; $display("FAIL rst_outs got=%b exp=0000", {irq, core_start, avs_readdatavalid, avs_waitrequest}); end
    total++; if (avs_readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", avs_readdata); end
    reset = 1'b0;
    tick(1);
    bus_rd(6'h01, d, v);
    total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL rst_status got=%b/%h exp=1/0", v, d); end
    bus_rd(6'h20, d, v);
    total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL rst_buf got=%b/%h exp=1/0", v, d); end
    tick(1);
    total++; if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin bad++; $display("FAIL rvalid_pulse got=%b/%h exp=0/0", avs_readdatavalid, avs_readdata); end
    bus_rd(6'h02, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_cycles got=%h exp=0", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    for (int i = 0; i < 32; i++) begin exp_in[i] = '0; exp_res[i] = '0; end
    exp_cycles = '0;
  endtask

  task automatic test_transform();
    logic [31:0] d; logic v; int k; int s0;
    for (int n = 0; n < 32; n++) buf_wr(n, 32'(n), 4'hF);
    core_en = 1'b1; core_lat = 10; s0 = n_starts;
    bus_wr(6'h00, 32'h5, 4'($urandom));
    total++; if (core_start !== 1'b1) begin bad++; $display("FAIL start_latency got=%b exp=1", core_start); end
    total++; if (core_data_in !== pack_in()) begin bad++; $display("FAIL start_data got=%h exp=%h", core_data_in[63:0], pack_in() >> 0); end
    k = 0;
    while (k < 40) begin
      tick(1); k++;
      if (k == 1) begin
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL start_width got=%b exp=0", core_start); end
      end
      if (irq === 1'b1) break;
    end
    total++; if (k !== 11) begin bad++; $display("FAIL irq_latency got=%0d exp=11", k); end
    for (int i = 0; i < 32; i++) exp_res[i] = ~exp_in[i];
    exp_cycles = 32'd10;
    bus_rd(6'h02, d, v);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL cycles got=%0d exp=10", d); end
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL status_done got=%h exp=2", d); end
    bus_rd(6'h25, d, v);
    total++; if (d !== 32'hFFFFFFFA) begin bad++; $display("FAIL res_word5 got=%h exp=fffffffa", d); end
    total++; if (n_starts - s0 !== 1) begin bad++; $display("FAIL start_count got=%0d exp=1", n_starts - s0); end
    bus_wr(6'h00, 32'h0, 4'h0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_en_clear got=%b exp=0", irq); end
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL status_keep got=%h exp=2", d); end
  endtask

  task automatic test_byteenable();
    int ok;
    logic [31:0] d; logic v;
    buf_wr(0, 32'h0, 4'hF);
    buf_wr(0, 32'hAABBCCDD, 4'b0010);
    repeat (4) buf_wr($urandom_range(1, 31), $urandom, 4'($urandom_range(0, 15)));
    core_lat = $urandom_range(3, 12);
    bus_wr(6'h00, 32'h1, 4'($urandom));
    total++; if (core_data_in[31:0] !== 32'h0000CC00) begin bad++; $display("FAIL be_lane got=%h exp=0000cc00", core_data_in[31:0]); end
    total++; if (core_data_in !== pack_in()) begin bad++; $display("FAIL be_snapshot got=%h exp=%h", core_data_in[255:0], pack_in() >> 0); end
    wait_done(ok);
    total++; if (ok !== 1) begin bad++; $display("FAIL be_done_timeout got=%0d exp=1", ok); end
    for (int i = 0; i < 32; i++) exp_res[i] = ~exp_in[i];
    exp_cycles = 32'(core_lat);
    bus_rd(6'h02, d, v);
    total++; if (d !== exp_cycles) begin bad++; $display("FAIL be_cycles got=%0d exp=%0d", d, exp_cycles); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL be_irq_off got=%b exp=0", irq); end
  endtask

  task automatic test_busy_write();
    int ok; int s0;
    logic [31:0] d; logic v; logic [1023:0] snap;
    snap = pack_in(); core_lat = 12;
    tick(1); s0 = n_starts;
    bus_wr(6'h00, 32'h1, 4'hF);
    tick(2);
    bus_wr(6'h23, $urandom | 32'h1, 4'hF);
    bus_wr(6'h00, 32'h1, 4'hF);
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'h9) begin bad++; $display("FAIL busy_status got=%h exp=9", d); end
    total++; if (core_data_in !== snap) begin bad++; $display("FAIL busy_data got=%h exp=%h", core_data_in[127:96], snap[127:96]); end
    wait_done(ok);
    total++; if (ok !== 1) begin bad++; $display("FAIL busy_done_timeout got=%0d exp=1", ok); end
    for (int i = 0; i < 32; i++) exp_res[i] = ~exp_in[i];
    exp_cycles = 32'd12;
    tick(2);
    total++; if (n_starts - s0 !== 1) begin bad++; $display("FAIL busy_starts got=%0d exp=1", n_starts - s0); end
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'hA) begin bad++; $display("FAIL busy_after got=%h exp=a", d); end
    bus_rd(6'h23, d, v);
    total++; if (d !== exp_res[3]) begin bad++; $display("FAIL busy_drop got=%h exp=%h", d, exp_res[3]); end
    bus_wr(6'h00, 32'h2, 4'($urandom));
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL clear_status got=%h exp=0", d); end
  endtask

  task automatic test_timeout();
    int k; int idx;
    logic [31:0] d; logic v;
    core_en = 1'b0;
    bus_wr(6'h00, 32'h5, 4'($urandom));
    k = 0;
    while (k < 40) begin
      tick(1); k++;
      if (irq === 1'b1) break;
    end
    total++; if (k !== TO + 1) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", k, TO + 1); end
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL timeout_status got=%h exp=4", d); end
    #1 late_req = 1'b1;
    @(negedge clk);
    #1 late_req = 1'b0;
    tick(2);
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL late_status got=%h exp=4", d); end
    for (int j = 0; j < 4; j++) begin
      idx = $urandom_range(0, 31);
      bus_rd(6'(32 + idx), d, v);
      total++; if (d !== exp_res[idx]) begin bad++; $display("FAIL late_res[%0d] got=%h exp=%h", idx, d, exp_res[idx]); end
    end
    bus_rd(6'h02, d, v);
    total++; if (d !== exp_cycles) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", d, exp_cycles); end
    core_en = 1'b1;
    bus_wr(6'h00, 32'h6, 4'h0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL clear_irq got=%b exp=0", irq); end
  endtask

  task automatic test_clear_start();
    int s0;
    logic [31:0] d; logic v;
    tick(1); s0 = n_starts;
    bus_wr(6'h00, 32'h3, 4'($urandom));
    tick(3);
    total++; if (n_starts - s0 !== 0) begin bad++; $display("FAIL idle_clear_start got=%0d exp=0", n_starts - s0); end
    core_lat = 14;
    bus_wr(6'h00, 32'h5, 4'hF);
    tick(3);
    bus_wr(6'h00, 32'h7, 4'($urandom));
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_status got=%h exp=0", d); end
    tick(16);
    total++; if (n_starts - s0 !== 1) begin bad++; $display("FAIL abort_starts got=%0d exp=1", n_starts - s0); end
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'h0 || irq !== 1'b0) begin bad++; $display("FAIL abort_late got=%h/%b exp=0/0", d, irq); end
    bus_rd(6'h20, d, v);
    total++; if (d !== exp_res[0]) begin bad++; $display("FAIL abort_res got=%h exp=%h", d, exp_res[0]); end
    bus_wr(6'h00, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    int ok;
    logic [31:0] d; logic v;
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 32; n++) buf_wr(n, $urandom, 4'($urandom_range(1, 15)));
      core_lat = $urandom_range(3, 14);
      bus_wr(6'h00, 32'h1, 4'($urandom));
      wait_done(ok);
      total++; if (ok !== 1) begin bad++; $display("FAIL b2b_done_timeout got=%0d exp=1", ok); end
      total++; if (seen_in !== pack_in()) begin bad++; $display("FAIL b2b_snapshot got=%h exp=%h", seen_in[127:0], pack_in() >> 0); end
      for (int i = 0; i < 32; i++) exp_res[i] = ~exp_in[i];
      exp_cycles = 32'(core_lat);
      for (int i = 0; i < 32; i++) begin
        avs_read = 1'b1; avs_address = 6'(32 + i);
        @(negedge clk);
        total++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_res[i]) begin bad++; $display("FAIL b2b_res[%0d] got=%b/%h exp=1/%h", i, avs_readdatavalid, avs_readdata, exp_res[i]); end
      end
      avs_read = 1'b0;
      bus_rd(6'h02, d, v);
      total++; if (d !== exp_cycles) begin bad++; $display("FAIL b2b_cycles got=%0d exp=%0d", d, exp_cycles); end
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    logic [31:0] d; logic v;
    core_lat = 5;
    tick(1); s0 = n_starts;
    bus_wr(6'h00, 32'h5, 4'hF);
    total++; if (core_start !== 1'b1) begin bad++; $display("FAIL rm_launch got=%b exp=1", core_start); end
    #2 reset = 1'b1;
    #1;
    total++; if (core_start !== 1'b0 || core_data_in !== '0) begin bad++; $display("FAIL rm_async_launch got=%b/%h exp=0/0", core_start, core_data_in[31:0]); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 32; i++) begin exp_in[i] = '0; exp_res[i] = '0; end
    exp_cycles = '0;
    tick(12);
    total++; if (n_starts - s0 !== 1) begin bad++; $display("FAIL rm_no_start got=%0d exp=1", n_starts - s0); end
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'h0 || irq !== 1'b0) begin bad++; $display("FAIL rm_status got=%h/%b exp=0/0", d, irq); end
    bus_rd(6'h20, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rm_res got=%h exp=0", d); end
    bus_rd(6'h02, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rm_cycles got=%h exp=0", d); end
    buf_wr(7, $urandom | 32'h1, 4'hF);
    core_lat = 12;
    bus_wr(6'h00, 32'h1, 4'hF);
    tick(3);
    avs_read = 1'b1; avs_address = 6'h01;
    @(negedge clk);
    avs_read = 1'b0;
    total++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h1) begin bad++; $display("FAIL rm_busy_rd got=%b/%h exp=1/1", avs_readdatavalid, avs_readdata); end
    #2 reset = 1'b1;
    #1;
    total++; if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0 || core_data_in !== '0) begin bad++; $display("FAIL rm_async_wait got=%b/%h/%h exp=0/0/0", avs_readdatavalid, avs_readdata, core_data_in[255:224]); end
    @(negedge clk); reset = 1'b0;
    tick(16);
    bus_rd(6'h01, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rm_wait_status got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_transform();
    test_byteenable();
    test_busy_write();
    test_timeout();
    test_clear_start();
    test_back_to_back();
    test_reset_mid();
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/curl_avalon_ctrl.md
Name: curl_avalon_ctrl

Overview:
- Avalon-MM slave controller that sequences the curl transform core inside the curl calc unit.
- Host CPU fills a 128-byte (1024-bit) input buffer with 32-bit writes and starts a transform. The block launches the core, waits for completion and captures the 1024-bit result into a readable buffer.
- Raises a level interrupt on completion or on timeout.
- Sits between the HPS/Avalon interconnect and the curl core.

Parameters:
- TIMEOUT_CYCLES, 4096, cycles allowed from core_start to core_done before abort; 0 disables the timeout.
- READ_LATENCY, 1, fixed Avalon read latency in cycles; only 1 is supported.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- avs_address  in  6  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_byteenable  in  4  byte lanes for writes
- avs_readdata  out  32  read data
- avs_readdatavalid  out  1  read data valid
- avs_waitrequest  out  1  always 0; the slave never stalls
- irq  out  1  interrupt, level, active-high
- core_start  out  1  one-cycle launch pulse to the curl core
- core_data_in  out  1024  input state to the core; stable while busy
- core_done  in  1  one-cycle completion pulse from the core
- core_data_out  in  1024  core result; valid in the cycle core_done=1

Behaviour:
- Register map (word addresses):
  - 0x00 CTRL (W): bit0 START, bit1 CLEAR, bit2 IRQ_EN.
  - 0x01 STATUS (R): bit0 BUSY, bit1 DONE, bit2 TIMEOUT, bit3 WR_ERR.
  - 0x02 CYCLES (R): core cycle count of the last run.
  - 0x20-0x3F: input buffer on write, result buffer on read. Word n maps to bits [32n+31:32n], little-endian byte order (byte k of the 128-byte view = bits [8k+7:8k]).
  - Unmapped addresses: reads return 0, writes are ignored.
- Reset values:
  - All outputs 0; STATE=IDLE; buffers 0; CYCLES 0; all STATUS bits 0; IRQ_EN 0.
- Reads:
  - avs_readdatavalid asserts exactly 1 cycle after avs_read.
  - avs_readdata holds the sampled value in that cycle and is 0 otherwise.
  - Back-to-back reads are supported at 1 per cycle.
- Writes:
  - Byteenable is honoured per lane on buffer writes.
  - CTRL bits apply on a write regardless of byteenable[0].
  - An input-buffer write while BUSY is dropped and sets WR_ERR.
- State machine:
  - IDLE: START=1 -> LAUNCH, set BUSY, clear DONE and TIMEOUT. START while BUSY is ignored.
  - LAUNCH (1 cycle): core_start=1, core_data_in = input buffer snapshot, cycle counter := 0 -> WAIT.
  - WAIT: counter increments each cycle.
    - core_done=1 -> capture core_data_out into the result buffer, CYCLES := counter+1, set DONE, clear BUSY -> IDLE.
    - counter reaches TIMEOUT_CYCLES-1 without core_done -> set TIMEOUT, clear BUSY, result buffer unchanged -> IDLE.
  - A core_done that arrives outside WAIT is ignored.
- CLEAR:
  - Clears DONE, TIMEOUT and WR_ERR.
  - In WAIT it aborts to IDLE (BUSY=0, no capture); a later core_done is ignored.
  - CLEAR and START written together: CLEAR takes priority and START is dropped.
- irq:
  - irq = IRQ_EN & (DONE | TIMEOUT), registered.
  - Cleared by CLEAR or by writing IRQ_EN=0.
- Latency:
  - START write accepted at cycle t -> core_start at t+1.
  - core_done at cycle d -> DONE visible in STATUS and irq high at d+1.
- Reset asserted mid-operation returns every register to its reset value immediately. core_start is never emitted after reset.

Test Plan:
- Reset, then read STATUS and buffer word 0x20 -> readdata=0 and readdatavalid pulses 1 cycle after each read; irq=0.
- Write words 0x20-0x3F with value n (bytes 0x00,0x00,0x00,n), start with IRQ_EN, core model returns ~data after 10 cycles -> core_start pulses 1 cycle; word 0x25 reads 0xFFFFFFFA; CYCLES=10; STATUS=0x2; irq=1.
- Byteenable=4'b0010, writedata=0xAABBCCDD to 0x20 (previously 0) -> core_data_in[31:0]=0x0000CC00 at the next launch.
- Buffer write and second START while BUSY -> write dropped, WR_ERR=1, only one core_start seen, core_data_in unchanged.
- TIMEOUT_CYCLES=16, core never responds -> STATUS=0x4 on the 17th cycle after launch; a late core_done does not alter the result buffer.
- CLEAR|START in the same write during WAIT, plus reset asserted during WAIT in a separate run -> CLEAR aborts without a new launch; reset returns all outputs to 0 asynchronously.
